vram_arbiter: RTL and testbench

- Time-division scheduler sharing one single-port, pipelined frame-buffer RAM between VGA scanout and a CPU master.
- Runs on the 50 MHz clock. Each 25 MHz pixel period gives one display slot and one CPU slot.
- Converts the VGA X/Y/DISP outputs into RAM reads, expands the stored RGB332 byte to the 24-bit C_R/C_G/C_B colour, and serves CPU reads and writes through a req/ack handshake.

---
 rtl/vram_arbiter.sv | 131 +++++++++++++
 tb/tb_vram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Time-division arbiter for a single-port pipelined frame-buffer RAM:
// display reads own the PIX_PHASE=0 slot while DISP=1, the CPU gets every other slot.
module vram_arbiter #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              PIX_PHASE,
  input  logic              DISP,
  input  logic [9:0]        X,
  input  logic [9:0]        Y,
  output logic [7:0]        C_R,
  output logic [7:0]        C_G,
  output logic [7:0]        C_B,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned FB_W = H_RES >> SCALE_SHIFT;
  localparam int unsigned FB_H = V_RES >> SCALE_SHIFT;
  localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(FB_W * FB_H);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACK     = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  logic [1:0]        state;
  logic              disp_slot, blank_slot, cpu_oor, cpu_go;
  logic [ADDR_W-1:0] disp_addr;

  // Issue-stage tag travels with mem_addr; the RD_LAT stages then line up with mem_rdata.
  logic              iss_v, iss_cpu, iss_blank;
  logic [RD_LAT-1:0] tag_v, tag_cpu, tag_blank;
  logic              em_v, em_cpu, em_blank;

  always_comb begin
    disp_slot  = ~PIX_PHASE & DISP;
    blank_slot = ~PIX_PHASE & ~DISP;
    cpu_oor    = {1'b0, cpu_addr} >= FB_LIMIT;
    // cpu_ack high means this edge closes an ack cycle: the held request is ignored.
    cpu_go     = (state == ST_IDLE) & ~cpu_ack & cpu_req & ~disp_slot;
    // Low ADDR_W bits equal the ADDR_W+1-bit product-plus-column truncated.
    disp_addr  = ADDR_W'(Y >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(X >> SCALE_SHIFT);
    em_v       = tag_v[RD_LAT-1];
    em_cpu     = tag_cpu[RD_LAT-1];
    em_blank   = tag_blank[RD_LAT-1];
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      iss_v     <= 1'b0;
      iss_cpu   <= 1'b0;
      iss_blank <= 1'b0;
      tag_v     <= '0;
      tag_cpu   <= '0;
      tag_blank <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      C_R       <= '0;
      C_G       <= '0;
      C_B       <= '0;
    end else begin
      mem_we    <= 1'b0;
      iss_v     <= 1'b0;
      iss_cpu   <= 1'b0;
      iss_blank <= blank_slot;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;

      if (disp_slot) begin
        mem_addr <= disp_addr;
        iss_v    <= 1'b1;
      end else if (cpu_go && !cpu_oor) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
        iss_v     <= ~cpu_we;
        iss_cpu   <= ~cpu_we;
      end

      tag_v     <= RD_LAT'({tag_v, iss_v});
      tag_cpu   <= RD_LAT'({tag_cpu, iss_cpu});
      tag_blank <= RD_LAT'({tag_blank, iss_blank});

      case (state)
        ST_IDLE: begin
          if (cpu_go) state <= (cpu_we || cpu_oor) ? ST_ACK : ST_RD_WAIT;
        end
        ST_ACK: begin
          cpu_ack <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (em_v && em_cpu) begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= mem_rdata;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (em_v && !em_cpu) begin
        C_R <= {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]};
        C_G <= {mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3]};
        C_B <= {4{mem_rdata[1:0]}};
      end else if (em_blank) begin
        C_R <= '0;
        C_G <= '0;
        C_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a behavioural pipelined RAM.
module tb_vram_arbiter;

  localparam int unsigned AW = 17;

  logic clk = 1'b0, rst = 1'b1, pix = 1'b0, disp = 1'b0;
  logic [9:0] x = '0, y = '0;

  logic [7:0] cr_a, cg_a, cb_a, rdata_a, mwd_a, mrd_a;
  logic ack_a, mwe_a;
  logic [AW-1:0] maddr_a;
  logic req_a = 1'b0, we_a = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [7:0] wd_a = '0;

  logic [7:0] cr_b, cg_b, cb_b, rdata_b, mwd_b, mrd_b;
  logic ack_b, mwe_b;
  logic [AW-1:0] maddr_b;
  logic req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [7:0] wd_b = '0;

  int n_chk = 0;
  int n_fail = 0;

  vram_arbiter #(.RD_LAT(1)) dut_a (
    .CLK(clk), .RES(rst), .PIX_PHASE(pix), .DISP(disp), .X(x), .Y(y),
    .C_R(cr_a), .C_G(cg_a), .C_B(cb_a),
    .cpu_req(req_a), .cpu_we(we_a), .cpu_addr(addr_a), .cpu_wdata(wd_a),
    .cpu_ack(ack_a), .cpu_rdata(rdata_a),
    .mem_addr(maddr_a), .mem_we(mwe_a), .mem_wdata(mwd_a), .mem_rdata(mrd_a)
  );

  vram_arbiter #(.RD_LAT(3)) dut_b (
    .CLK(clk), .RES(rst), .PIX_PHASE(pix), .DISP(disp), .X(x), .Y(y),
    .C_R(cr_b), .C_G(cg_b), .C_B(cb_b),
    .cpu_req(req_b), .cpu_we(we_b), .cpu_addr(addr_b), .cpu_wdata(wd_b),
    .cpu_ack(ack_b), .cpu_rdata(rdata_b),
    .mem_addr(maddr_b), .mem_we(mwe_b), .mem_wdata(mwd_b), .mem_rdata(mrd_b)
  );

  logic [7:0] ram_a [0:(1<<AW)-1];
  logic [7:0] ram_b [0:(1<<AW)-1];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (mwe_a) ram_a[maddr_a] <= mwd_a;
    pipe_a <= ram_a[maddr_a];
    if (mwe_b) ram_b[maddr_b] <= mwd_b;
    pipe_b[0] <= ram_b[maddr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrd_a = pipe_a;
  assign mrd_b = pipe_b[2];

  // PIX_PHASE flips just after each rising edge, so at a falling edge it shows the next slot.
  initial begin
    forever begin
      #10 clk = 1'b1;
      #1  pix = ~pix;
      #9  clk = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Simple master: request at a falling edge, hold until ack, drop on the ack cycle.
  task automatic cpu_xfer(input bit sel, input logic we, input logic [AW-1:0] addr,
                          input logic [7:0] wd, output logic [7:0] rd, output int lat);
    @(negedge clk);
    if (sel) begin req_b = 1'b1; we_b = we; addr_b = addr; wd_b = wd; end
    else     begin req_a = 1'b1; we_a = we; addr_a = addr; wd_a = wd; end
    lat = 0;
    rd  = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? ack_b : ack_a) begin
        rd = sel ? rdata_b : rdata_a;
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  logic [7:0] rd;
  int lat;
  bit seen;

  initial begin
    cycles(3);
    check_eq("rst_color_a", 32'({cr_a, cg_a, cb_a}), 32'h0);
    check_eq("rst_mem_a", 32'({mwe_a, maddr_a, mwd_a}), 32'h0);
    check_eq("rst_cpu_a", 32'({ack_a, rdata_a}), 32'h0);
    check_eq("rst_cpu_b", 32'({ack_b, mwe_b}), 32'h0);
    rst = 1'b0;
    cycles(2);

    // Write during blanking with the request held one cycle past the ack.
    req_a = 1'b1; we_a = 1'b1; addr_a = 17'd100; wd_a = 8'h1C;
    @(negedge clk);
    check_eq("wr_strobe", 32'({mwe_a, maddr_a, mwd_a}), 32'({1'b1, 17'd100, 8'h1C}));
    check_eq("wr_no_early_ack", 32'(ack_a), 32'h0);
    @(negedge clk);
    check_eq("wr_one_cycle", 32'(mwe_a), 32'h0);
    check_eq("wr_ack", 32'(ack_a), 32'h1);
    @(negedge clk);
    check_eq("wr_hold_ack", 32'({ack_a, mwe_a}), 32'h0);
    req_a = 1'b0;
    @(negedge clk);
    check_eq("wr_hold_ack2", 32'({ack_a, mwe_a}), 32'h0);

    cpu_xfer(0, 1'b0, 17'd100, 8'h00, rd, lat);
    check_eq("rd100_data", 32'(rd), 32'h1C);
    check_eq("rd100_lat", 32'(lat), 32'd3);
    cpu_xfer(0, 1'b1, 17'd645, 8'hE3, rd, lat);
    check_eq("wr645_lat", 32'(lat), 32'd2);
    cpu_xfer(0, 1'b1, 17'd76799, 8'h77, rd, lat);
    check_eq("wr_last_lat", 32'(lat), 32'd2);
    cpu_xfer(0, 1'b0, 17'd76799, 8'h00, rd, lat);
    check_eq("rd_last_data", 32'(rd), 32'h77);

    // Out-of-range write then read.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 17'd76800; wd_a = 8'hAB;
    @(negedge clk);
    check_eq("oor_wr_no_we", 32'(mwe_a), 32'h0);
    @(negedge clk);
    check_eq("oor_wr_ack", 32'({ack_a, mwe_a}), 32'h2);
    req_a = 1'b0;
    cpu_xfer(0, 1'b0, 17'd76800, 8'h00, rd, lat);
    check_eq("oor_rd_lat", 32'(lat), 32'd2);
    check_eq("oor_rd_data", 32'(rd), 32'h0);

    // Display fetch X=10,Y=4 on the RD_LAT=1 instance, then blank.
    @(negedge clk);
    if (pix) @(negedge clk);
    x = 10'd10; y = 10'd4; disp = 1'b1;
    @(negedge clk);
    check_eq("disp_addr", 32'({mwe_a, maddr_a}), 32'({1'b0, 17'd645}));
    check_eq("disp_not_yet1", 32'({cr_a, cg_a, cb_a}), 32'h0);
    disp = 1'b0;
    @(negedge clk);
    check_eq("disp_not_yet2", 32'({cr_a, cg_a, cb_a}), 32'h0);
    @(negedge clk);
    check_eq("disp_color", 32'({cr_a, cg_a, cb_a}), 32'hFF00FF);
    @(negedge clk);
    check_eq("disp_hold", 32'({cr_a, cg_a, cb_a}), 32'hFF00FF);
    @(negedge clk);
    check_eq("blank_color", 32'({cr_a, cg_a, cb_a}), 32'h0);

    // Reset with a CPU read in flight on the RD_LAT=3 instance.
    req_b = 1'b1; we_b = 1'b0; addr_b = 17'd100;
    @(negedge clk);
    check_eq("inflight_addr", 32'({mwe_b, maddr_b}), 32'({1'b0, 17'd100}));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_b", 32'({ack_b, rdata_b, mwe_b, maddr_b}), 32'h0);
    check_eq("rst_async_col", 32'({cr_b, cg_b, cb_b}), 32'h0);
    req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_b) seen = 1'b1;
    end
    check_eq("no_ack_after_rst", 32'(seen), 32'h0);
    cpu_xfer(1, 1'b1, 17'd200, 8'h5A, rd, lat);
    check_eq("b_idle_wr_lat", 32'(lat), 32'd2);
    cpu_xfer(1, 1'b1, 17'd970, 8'h92, rd, lat);

    // CPU read contending with display on the RD_LAT=3 instance.
    @(negedge clk);
    x = 10'd20; y = 10'd6; disp = 1'b1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 17'd200;
    seen = 1'b0;
    rd = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (pix) check_eq("cont_disp_slot", 32'({mwe_b, maddr_b}), 32'({1'b0, 17'd970}));
      if (ack_b) begin
        seen = 1'b1;
        rd = rdata_b;
      end
    end
    req_b = 1'b0;
    check_eq("cont_ack_seen", 32'(seen), 32'h1);
    check_eq("cont_rdata", 32'(rd), 32'h5A);
    @(negedge clk);
    check_eq("cont_single_ack", 32'(ack_b), 32'h0);
    cycles(6);
    check_eq("cont_color", 32'({cr_b, cg_b, cb_b}), 32'h9292AA);

    // With DISP=0 the display-phase slot is usable by the CPU.
    disp = 1'b0;
    cycles(2);
    if (pix) @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 17'd300; wd_a = 8'h33;
    @(negedge clk);
    check_eq("blank_slot_cpu", 32'({mwe_a, maddr_a}), 32'({1'b1, 17'd300}));
    @(negedge clk);
    check_eq("blank_slot_ack", 32'(ack_a), 32'h1);
    req_a = 1'b0;
    cpu_xfer(0, 1'b0, 17'd300, 8'h00, rd, lat);
    check_eq("rd300_data", 32'(rd), 32'h33);

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
